// File: rtl/synapse_scheduler_if.sv
// Spike request / delivery bundle between presynaptic requesters and the scheduler.
// The master side drives spikes and configuration; the slave side is the scheduler.
interface synapse_scheduler_if #(
   parameter int N_REQ   = 4,
   parameter int DELAY_W = 4
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   spike_in;
   logic               enable;
   logic [DELAY_W-1:0] delay_cfg;
   logic               cfg_load;
   logic               spike_out;
   logic [ID_W-1:0]    spike_id;
   logic               busy;
   logic [N_REQ-1:0]   pending;
   logic [7:0]         drop_cnt;

   modport master (
      output spike_in, enable, delay_cfg, cfg_load,
      input  spike_out, spike_id, busy, pending, drop_cnt
   );

   modport slave (
      input  spike_in, enable, delay_cfg, cfg_load,
      output spike_out, spike_id, busy, pending, drop_cnt
   );
endinterface

// File: rtl/synapse_scheduler.sv
// Round-robin scheduler that captures presynaptic spike edges and replays them,
// one at a time, through a single programmable delay line.
//
// state | meaning
// IDLE  | waiting for enable and a pending spike to grant
// DELAY | counting the granted spike's delay down to 1
// FIRE  | one-cycle spike_out pulse for spike_id
module synapse_scheduler #(
   parameter int N_REQ   = 4,
   parameter int DELAY_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   synapse_scheduler_if.slave bus
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW1  = ID_W + 1;
   localparam logic [ID_W:0] N_L = IW1'(N_REQ);

   typedef enum logic [1:0] {S_IDLE, S_DELAY, S_FIRE} state_t;

   state_t             state_q, state_d;
   logic [N_REQ-1:0]   spike_q, spike_d;
   logic [N_REQ-1:0]   pending_q, pending_d;
   logic [7:0]         drop_cnt_q, drop_cnt_d;
   logic [ID_W-1:0]    last_grant_q, last_grant_d;
   logic [ID_W-1:0]    spike_id_q, spike_id_d;
   logic [DELAY_W-1:0] cnt_q, cnt_d;
   logic [DELAY_W-1:0] delay_reg_q, delay_reg_d;

   logic [N_REQ-1:0]   rise;
   logic [N_REQ-1:0]   gnt_vec;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_found;
   logic               grant;
   logic               drop;
   logic [ID_W:0]      cand_sum;

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand_sum  = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand_sum = {1'b0, last_grant_q} + IW1'(i);
         if (cand_sum >= N_L) cand_sum = cand_sum - N_L;
         if (!gnt_found && pending_q[cand_sum[ID_W-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand_sum[ID_W-1:0];
         end
      end
      grant   = (state_q == S_IDLE) && bus.enable && gnt_found;
      gnt_vec = '0;
      for (int j = 0; j < N_REQ; j++) begin
         gnt_vec[j] = grant && (gnt_idx == ID_W'(j));
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      spike_id_d   = spike_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               spike_id_d   = gnt_idx;
               last_grant_d = gnt_idx;
               cnt_d        = delay_reg_q;
               state_d      = (delay_reg_q == '0) ? S_FIRE : S_DELAY;
            end
         end
         S_DELAY: begin
            if (cnt_q == DELAY_W'(1)) state_d = S_FIRE;
            else                      cnt_d   = cnt_q - DELAY_W'(1);
         end
         S_FIRE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A fresh rise always wins over the grant clearing the same bit.
   always_comb begin
      spike_d     = bus.spike_in;
      rise        = bus.spike_in & ~spike_q;
      pending_d   = (pending_q & ~gnt_vec) | rise;
      drop        = |(rise & pending_q & ~gnt_vec);
      drop_cnt_d  = (drop && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
      delay_reg_d = bus.cfg_load ? bus.delay_cfg : delay_reg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         spike_q      <= '0;
         pending_q    <= '0;
         drop_cnt_q   <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         spike_id_q   <= '0;
         cnt_q        <= '0;
         delay_reg_q  <= DELAY_W'(3);
      end else begin
         state_q      <= state_d;
         spike_q      <= spike_d;
         pending_q    <= pending_d;
         drop_cnt_q   <= drop_cnt_d;
         last_grant_q <= last_grant_d;
         spike_id_q   <= spike_id_d;
         cnt_q        <= cnt_d;
         delay_reg_q  <= delay_reg_d;
      end
   end

   assign bus.spike_out = (state_q == S_FIRE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.spike_id  = spike_id_q;
   assign bus.pending   = pending_q;
   assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: doc/synapse_scheduler.md
SYNAPSE_SCHEDULER -- requirements
Module: synapse_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of presynaptic spike requesters sharing one delay line.
REQ-002 Parameter DELAY_W, default 4: width of the delay counter and configuration register.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 spike_in  input  N_REQ  presynaptic spike levels; a 0->1 transition is one spike.
REQ-006 enable  input  1  permits new grants when high.
REQ-007 delay_cfg  input  DELAY_W  delay value to load.
REQ-008 cfg_load  input  1  load strobe for delay_cfg.
REQ-009 spike_out  output  1  one-cycle delayed spike to the postsynaptic neuron.
REQ-010 spike_id  output  log2(N_REQ)  index of the requester whose spike is being delivered.
REQ-011 busy  output  1  high when the state is not IDLE.
REQ-012 pending  output  N_REQ  per-requester captured-but-not-granted spikes.
REQ-013 drop_cnt  output  8  saturating count of dropped spikes.

Function
REQ-014 Edge detect SHALL use a registered copy spike_q; rise[i] = spike_in[i] & ~spike_q[i], sampled at each clock edge.
REQ-015 rise[i] SHALL set pending[i] at the same edge.
REQ-016 rise[i] while pending[i]=1 and requester i is not granted at that edge SHALL count as a drop; drop_cnt SHALL increment by 1 per edge with any drop, saturating at 255.
REQ-017 States: IDLE, DELAY, FIRE.
REQ-018 IDLE with enable=1 and pending!=0: grant the first set pending bit searching round-robin from last_grant+1 (mod N_REQ); clear that pending bit, latch spike_id and last_grant, load counter with delay_reg.
REQ-019 On a grant, the next state SHALL be FIRE if delay_reg=0, otherwise DELAY.
REQ-020 DELAY: if counter=1, go to FIRE; otherwise decrement the counter.
REQ-021 FIRE SHALL last exactly one cycle with spike_out=1, then return to IDLE unconditionally.
REQ-022 Latency: a rise sampled at edge k with an immediate grant at edge k+1 SHALL drive spike_out high during the cycle after edge k+1+delay_reg.
REQ-023 Minimum spacing between spike_out pulses SHALL be delay_reg+2 cycles.
REQ-024 spike_out SHALL be 0 in IDLE and DELAY; spike_id SHALL hold its last granted value outside FIRE.
REQ-025 cfg_load=1 SHALL load delay_reg from delay_cfg at any state; a delay already loaded into the counter SHALL be unaffected, and the new value applies from the next grant.
REQ-026 enable=0 SHALL block new grants only; an in-progress DELAY/FIRE completes and spikes are still captured.
REQ-027 A rise on the requester being granted at the same edge SHALL leave pending set (set wins) and SHALL NOT count as a drop.
REQ-028 All outputs SHALL be registered or decoded from state only.

Reset
REQ-029 rst_n=0 SHALL immediately set: state IDLE, spike_out 0, spike_id 0, pending 0, spike_q 0, drop_cnt 0, last_grant N_REQ-1, counter 0, delay_reg 3.
REQ-030 Reset asserted during DELAY or FIRE SHALL abort delivery; no spike_out pulse follows the release of reset.

Verification
REQ-031 Reset, then a spike_in[0] rise sampled at edge k (delay_reg=3) -> spike_out=1 and spike_id=0 for one cycle after edge k+4; busy high from edge k+1 through FIRE.
REQ-032 cfg_load with delay_cfg=0, then a spike_in[2] rise -> spike_out during the cycle after edge k+1, spike_id=2.
REQ-033 Rises on requesters 0-3 at the same edge with delay_reg=1 -> four pulses with spike_id 0,1,2,3, each 3 cycles apart; pending drains 1111->1110->1100->1000->0000.
REQ-034 Second rise on requester 1 while pending[1]=1 and the scheduler is busy -> drop_cnt increments by 1 and exactly one pulse is delivered for requester 1.
REQ-035 enable=0 with pending=0101 -> no grant and busy=0; after enable=1, requesters 0 then 2 are delivered.
REQ-036 rst_n pulsed low mid-DELAY -> outputs return to reset values asynchronously and no spike_out follows; 300 forced drops -> drop_cnt=255.
